fifo_buffer: RTL and testbench

FIFO_BUFFER -- requirements
Module: fifo_buffer

---
 rtl/fifo_buffer_pkg.sv | 15 +
 rtl/fifo_buffer_if.sv | 31 +++
 rtl/fifo_buffer_mem.sv | 29 ++
 rtl/fifo_buffer.sv | 87 ++++++++
 tb/tb_fifo_buffer.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/fifo_buffer_pkg.sv
// Shared sizing for the FIFO buffer: default word width and depth, and the
// pointer-index width derived from the depth.
package fifo_buffer_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int DEPTH_DEF      = 8;

  // Index width needed to address 'depth' entries (depth is a power of two).
  function automatic int addr_width(input int depth);
    return $clog2(depth);
  endfunction

  localparam int ADDR_W_DEF = addr_width(DEPTH_DEF);

endpackage

// File: rtl/fifo_buffer_if.sv
// Producer/consumer handshake bundle for the FIFO buffer. The master side is
// the producer plus the downstream read controller; the slave side is the FIFO.
interface fifo_buffer_if
  import fifo_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_W     = ADDR_W_DEF
) ();

  logic                  write_en;
  logic [DATA_WIDTH-1:0] din;
  logic                  ready;
  logic                  pop;
  logic [DATA_WIDTH-1:0] dout;
  logic                  empty;
  logic                  full;
  logic [ADDR_W:0]       count;
  logic                  ovf;
  logic                  udf;

  modport master (
    output write_en, din, pop,
    input  ready, dout, empty, full, count, ovf, udf
  );

  modport slave (
    input  write_en, din, pop,
    output ready, dout, empty, full, count, ovf, udf
  );

endinterface

// File: rtl/fifo_buffer_mem.sv
// Storage array for the FIFO buffer: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module fifo_mem
  import fifo_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int ADDR_W     = addr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  // Store the pushed word at the write index on an accepted push.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/fifo_buffer.sv
// First-word fall-through FIFO. Pointers carry one extra wrap bit so that
// empty and full are told apart without a separate flag; count is kept as its
// own register and tracks wr_ptr - rd_ptr. Overflow/underflow are sticky.
module fifo_buffer
  import fifo_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int ADDR_W     = addr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  fifo_buffer_if.slave  bus
);

  localparam logic [ADDR_W:0] PTR_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0] wr_ptr_r;
  logic [ADDR_W:0] rd_ptr_r;
  logic [ADDR_W:0] count_r;
  logic            ovf_r;
  logic            udf_r;

  logic            empty_s;
  logic            full_s;
  logic            push_s;
  logic            pop_s;

  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[ADDR_W-1:0] == rd_ptr_r[ADDR_W-1:0]) &&
                   (wr_ptr_r[ADDR_W] != rd_ptr_r[ADDR_W]);

  // A request is only honoured when the queue can take it; the rest are errors.
  assign push_s = bus.write_en && !full_s;
  assign pop_s  = bus.pop && !empty_s;

  // Pointer, occupancy and sticky error-flag state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= PTR_ZERO;
      ovf_r    <= 1'b0;
      udf_r    <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + PTR_ONE;
        2'b01:   count_r <= count_r - PTR_ONE;
        default: count_r <= count_r;
      endcase
      if (bus.write_en && full_s) begin
        ovf_r <= 1'b1;
      end
      if (bus.pop && empty_s) begin
        udf_r <= 1'b1;
      end
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push_s),
    .waddr (wr_ptr_r[ADDR_W-1:0]),
    .wdata (bus.din),
    .raddr (rd_ptr_r[ADDR_W-1:0]),
    .rdata (bus.dout)
  );

  assign bus.empty = empty_s;
  assign bus.full  = full_s;
  assign bus.ready = ~full_s;
  assign bus.count = count_r;
  assign bus.ovf   = ovf_r;
  assign bus.udf   = udf_r;

endmodule

// File: tb/tb_fifo_buffer.sv
// Directed testbench for fifo_buffer: fill/drain, overflow/underflow,
// sustained push+pop with wrap, corner collisions and asynchronous reset.
module tb_fifo_buffer;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  fifo_buffer_if bus_if ();

  fifo_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Advance one edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus_if.write_en = 1'b0;
    bus_if.pop      = 1'b0;
    bus_if.din      = 8'h00;
  endtask

  // Pulse reset between clock edges.
  task automatic do_reset();
    idle();
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    step();
  endtask

  task automatic push(input logic [7:0] d);
    bus_if.write_en = 1'b1;
    bus_if.din      = d;
    step();
    bus_if.write_en = 1'b0;
  endtask

  task automatic pop_one();
    bus_if.pop = 1'b1;
    step();
    bus_if.pop = 1'b0;
  endtask

  initial begin
    logic [7:0] want_d;
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    idle();
    repeat (2) step();

    // Reset state.
    check("rst_empty", bus_if.empty, 1'b1);
    check("rst_full",  bus_if.full,  1'b0);
    check("rst_ready", bus_if.ready, 1'b1);
    check("rst_count", bus_if.count, 4'd0);
    check("rst_ovf",   bus_if.ovf,   1'b0);
    check("rst_udf",   bus_if.udf,   1'b0);
    #2 rst = 1'b1;
    step();

    // Fill with 0x11..0x88, then an overflowing 9th push.
    for (int i = 0; i < 8; i++) begin
      want_d = 8'(8'h11 * (i + 1));
      push(want_d);
    end
    check("fill_full",  bus_if.full,  1'b1);
    check("fill_ready", bus_if.ready, 1'b0);
    check("fill_count", bus_if.count, 4'd8);
    check("fill_ovf0",  bus_if.ovf,   1'b0);
    push(8'h99);
    check("ovf_set",    bus_if.ovf,   1'b1);
    check("ovf_count",  bus_if.count, 4'd8);
    check("ovf_head",   bus_if.dout,  8'h11);

    // Drain in order, then underflow.
    for (int i = 0; i < 8; i++) begin
      want_d = 8'(8'h11 * (i + 1));
      check("drain_dout", bus_if.dout, want_d);
      pop_one();
    end
    check("drain_empty", bus_if.empty, 1'b1);
    check("drain_count", bus_if.count, 4'd0);
    check("drain_udf0",  bus_if.udf,   1'b0);
    pop_one();
    check("udf_set",     bus_if.udf,   1'b1);
    check("udf_count",   bus_if.count, 4'd0);
    check("udf_ovf",     bus_if.ovf,   1'b1);

    // Sustained push+pop at count=3 across pointer wrap.
    do_reset();
    check("rst2_udf", bus_if.udf, 1'b0);
    check("rst2_ovf", bus_if.ovf, 1'b0);
    push(8'h01);
    push(8'h02);
    push(8'h03);
    for (int k = 0; k < 20; k++) begin
      want_d = (k < 3) ? 8'(k + 1) : 8'(8'h10 + k - 3);
      check("stream_dout",  bus_if.dout,  want_d);
      check("stream_count", bus_if.count, 4'd3);
      bus_if.write_en = 1'b1;
      bus_if.din      = 8'(8'h10 + k);
      bus_if.pop      = 1'b1;
      step();
    end
    idle();
    check("stream_end_count", bus_if.count, 4'd3);
    check("stream_end_dout",  bus_if.dout,  8'h21);
    check("stream_end_ovf",   bus_if.ovf,   1'b0);
    check("stream_end_udf",   bus_if.udf,   1'b0);

    // Empty with push+pop: only the push is taken.
    do_reset();
    bus_if.write_en = 1'b1;
    bus_if.din      = 8'hA5;
    bus_if.pop      = 1'b1;
    step();
    idle();
    check("ep_udf",   bus_if.udf,   1'b1);
    check("ep_dout",  bus_if.dout,  8'hA5);
    check("ep_count", bus_if.count, 4'd1);
    check("ep_empty", bus_if.empty, 1'b0);

    // Full with push+pop: only the pop is taken.
    do_reset();
    for (int i = 0; i < 8; i++) push(8'(8'h20 + i));
    bus_if.write_en = 1'b1;
    bus_if.din      = 8'h5A;
    bus_if.pop      = 1'b1;
    step();
    idle();
    check("fp_count", bus_if.count, 4'd7);
    check("fp_ovf",   bus_if.ovf,   1'b1);
    check("fp_ready", bus_if.ready, 1'b1);
    for (int i = 1; i < 8; i++) begin
      check("fp_drain", bus_if.dout, 8'(8'h20 + i));
      pop_one();
    end
    check("fp_empty", bus_if.empty, 1'b1);

    // Asynchronous reset mid-burst at count=5.
    do_reset();
    pop_one();
    for (int i = 0; i < 5; i++) push(8'(8'h40 + i));
    check("mid_count5", bus_if.count, 4'd5);
    check("mid_udf1",   bus_if.udf,   1'b1);
    bus_if.write_en = 1'b1;
    bus_if.din      = 8'h77;
    #2 rst = 1'b0;
    #1;
    check("mid_empty", bus_if.empty, 1'b1);
    check("mid_count", bus_if.count, 4'd0);
    check("mid_ovf",   bus_if.ovf,   1'b0);
    check("mid_udf",   bus_if.udf,   1'b0);
    idle();
    step();
    #2 rst = 1'b1;
    step();
    push(8'h3C);
    check("post_dout",  bus_if.dout,  8'h3C);
    check("post_count", bus_if.count, 4'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
